player_motion_ctrl: RTL and testbench
=====================================

# player_motion_ctrl

Per-frame player motion controller that sits directly upstream of the player sprite generator. It turns debounced button levels into sprite origin (x0, y0) and the 5-bit sprite control word: colour select, auto-animate flag, and sprite id. It runs a walk/jump/fall state machine with gravity. State advances once per video frame, using a frame tick derived from the same pixel scan coordinates the sprite generator receives.

## Interface
Parameters:
- X_INIT, 304, x0 after reset
- X_MAX, 608, largest legal x0 (640 − 32)
- Y_FLOOR, 448, ground y0 (480 − 32)
- WALK_SPD, 2, horizontal pixels per frame
- JUMP_V, 10, launch vertical speed, pixels/frame
- GRAV, 1, speed change per frame
- MAX_FALL, 8, fall speed ceiling

Ports (one clock `clk`; reset `reset` is synchronous, active-high):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- x  in  11  current scan x, same bus as the sprite generator's x
- y  in  11  current scan y
- btn_left  in  1  asynchronous button level
- btn_right  in  1  asynchronous button level
- btn_jump  in  1  asynchronous button level
- color_sel  in  2  skin colour selection, forwarded to ctrl[4:3]
- x0  out  11  sprite origin x, registered
- y0  out  11  sprite origin y, registered
- ctrl  out  5  {color_sel, auto, sid[1:0]}, registered
- airborne  out  1  high in JUMP or FALL, registered

## Operation
- **Button synchronisers**
  - Each button passes through a 2-flop synchroniser.
  - btn_jump additionally drives a rising-edge detector.
  - A detected edge sets `jump_req`.
  - `jump_req` clears on every frame update, whether or not the jump is consumed.
  - If an edge and a frame update coincide, the request is consumed by that update.
- **Frame tick**
  - x is registered as `x_d1`.
  - `frame_tick` = (x_d1==0) && (x==1) && (y==0).
  - All motion state updates only on a clock edge where `frame_tick` is high.
- **Direction**: dir = right-only → +WALK_SPD, left-only → −WALK_SPD, neither or both → 0.
- **Horizontal motion**
  - Applied in WALK, JUMP and FALL.
  - x0 saturates to [0, X_MAX] and never wraps.
- **Vertical speed** `vy`: 6-bit unsigned magnitude; the sign is implied by state.
- **States**
  - IDLE
    - jump_req → JUMP, y0 −= JUMP_V, vy = JUMP_V − GRAV.
    - Otherwise dir≠0 → WALK.
  - WALK
    - Moves x0.
    - jump_req → JUMP, with the same launch as IDLE.
    - dir==0 → IDLE.
  - JUMP
    - y0 −= vy, then vy −= GRAV.
    - If the new vy is 0 → FALL.
    - If y0 − vy < 0: y0 = 0, vy = 0 → FALL (ceiling).
  - FALL
    - vy = min(vy + GRAV, MAX_FALL), then y0 += vy.
    - If the result is ≥ Y_FLOOR: y0 = Y_FLOOR, vy = 0 → WALK if dir≠0, else IDLE.
- **ctrl output**
  - ctrl[4:3] = color_sel, re-registered every clock, not only on frame ticks.
  - ctrl[2] (auto) = 1 only in WALK.
  - sid: IDLE = 0, WALK = 0, JUMP = 2, FALL = 3.
- **In-air jump requests**: ignored in JUMP and FALL unless the configuration feature below is compiled in.

## Timing
- Reset values: x0 = X_INIT, y0 = Y_FLOOR, ctrl = 5'b00000, airborne = 0, state IDLE, vy = 0, jump_req = 0, synchronisers cleared.
- Button-to-logic latency:
  - 2 clocks for synchronisation.
  - +1 clock for the jump edge detector.
- x0, y0, ctrl[2:0] and airborne change exactly 1 clock after the cycle in which `frame_tick` is high. They are stable for the rest of the frame.
- ctrl[4:3] follows color_sel with 1 clock of latency.
- Reset asserted mid-frame or mid-jump: outputs return to reset values on the next clock. The next frame tick starts from IDLE.
- Arithmetic uses 12-bit signed intermediates, so underflow and overflow are detected before clamping.

## Configuration
- `PLAYER_DOUBLE_JUMP_EN` defined:
  - A 1-bit `air_jump_used` flag is added; it clears on landing and on reset.
  - A jump_req in JUMP or FALL while the flag is clear relaunches: y0 −= JUMP_V, vy = JUMP_V − GRAV, state JUMP, and the flag is set.
- Undefined:
  - The flag logic is absent.
  - In-air jump requests are discarded.

## Test plan
- **Reset**: hold reset for 3 clocks mid-scan → x0 = 304, y0 = 448, ctrl = 0, airborne = 0. No change until the first frame tick.
- **Walk right**:
  - btn_right held for 10 frames → x0 = 324 and ctrl[2] = 1.
  - Release → next frame ctrl[2] = 0 and sid = 0.
- **Right clamp**: start at x0 = 606, hold right for 3 frames → x0 = 608, 608, 608.
- **Left clamp**: start at x0 = 1, hold left for 1 frame → x0 = 0.
- **Full jump**:
  - Jump pulse → launch frame y0 = 438.
  - Apex y0 = 393 after 10 jump frames, then sid = 3.
  - Lands at y0 = 448 on fall frame 11, then airborne = 0 and sid = 0.
- **Simultaneous events**:
  - Jump edge arriving on the frame_tick clock is consumed that frame.
  - A second jump edge mid-air is ignored with the macro undefined.
  - With `PLAYER_DOUBLE_JUMP_EN`, the same second edge relaunches once, and a third edge is ignored.
- **Colour passthrough**: color_sel = 2'b10 → ctrl[4:3] = 2'b10 one clock later, with no frame tick required.

Source files
------------

// File: rtl/player_motion_ctrl.sv
// Per-frame player motion controller: walk/jump/fall FSM with gravity driving sprite origin and control word.
// Optional in-air relaunch enabled by defining PLAYER_DOUBLE_JUMP_EN.
module player_motion_ctrl #(
   parameter int X_INIT   = 304,
   parameter int X_MAX    = 608,
   parameter int Y_FLOOR  = 448,
   parameter int WALK_SPD = 2,
   parameter int JUMP_V   = 10,
   parameter int GRAV     = 1,
   parameter int MAX_FALL = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] x,
   input  logic [10:0] y,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_jump,
   input  logic [1:0]  color_sel,
   output logic [10:0] x0,
   output logic [10:0] y0,
   output logic [4:0]  ctrl,
   output logic        airborne
);
   // state  | meaning
   // S_IDLE | on floor, not moving
   // S_WALK | on floor, moving horizontally
   // S_JUMP | rising, vy is upward speed
   // S_FALL | descending, vy is downward speed
   typedef enum logic [1:0] {S_IDLE, S_WALK, S_JUMP, S_FALL} state_t;

   localparam logic signed [11:0] WALK_D    = 12'(WALK_SPD);
   localparam logic signed [11:0] X_MAX_S   = 12'(X_MAX);
   localparam logic signed [11:0] Y_FLOOR_S = 12'(Y_FLOOR);
   localparam logic signed [11:0] JUMP_V_S  = 12'(JUMP_V);
   localparam logic [5:0]         VY_LAUNCH = 6'(JUMP_V - GRAV);
   localparam logic [5:0]         GRAV_V    = 6'(GRAV);
   localparam logic [5:0]         MAX_F_V   = 6'(MAX_FALL);

   state_t      state, nxt_state;
   logic [5:0]  vy, nxt_vy;
   logic [10:0] nxt_x0, nxt_y0;
   logic [1:0]  nxt_sid;
   logic [10:0] x_d1;
   logic        left_s1, left_s2, right_s1, right_s2;
   logic        jump_s1, jump_s2, jump_s3;
   logic        jump_req;
   logic [2:0]  ctrl_lo;
   logic [1:0]  color_q;

   logic               frame_tick, jump_edge, jump_now;
   logic signed [11:0] dir, x_sum, y_launch, y_jmp, y_fall;
   logic [10:0]        x_clamped, y_launch_c;
   logic [6:0]         vy_sum;
   logic [5:0]         vy_inc;

`ifdef PLAYER_DOUBLE_JUMP_EN
   logic air_jump_used, nxt_air_jump_used;
`endif

   assign frame_tick = (x_d1 == 11'd0) && (x == 11'd1) && (y == 11'd0);
   assign jump_edge  = jump_s2 && !jump_s3;
   // an edge landing on the tick clock is consumed by that same update
   assign jump_now   = jump_req || jump_edge;
   assign ctrl       = {color_q, ctrl_lo};

   always_comb begin
      dir = 12'sd0;
      if (right_s2 && !left_s2)
         dir = WALK_D;
      else if (left_s2 && !right_s2)
         dir = -WALK_D;

      x_sum = $signed({1'b0, x0}) + dir;
      if (x_sum < 12'sd0)
         x_clamped = 11'd0;
      else if (x_sum > X_MAX_S)
         x_clamped = X_MAX_S[10:0];
      else
         x_clamped = x_sum[10:0];

      y_launch   = $signed({1'b0, y0}) - JUMP_V_S;
      y_launch_c = (y_launch < 12'sd0) ? 11'd0 : y_launch[10:0];
      y_jmp      = $signed({1'b0, y0}) - $signed({6'b0, vy});
      vy_sum     = {1'b0, vy} + {1'b0, GRAV_V};
      vy_inc     = (vy_sum > {1'b0, MAX_F_V}) ? MAX_F_V : vy_sum[5:0];
      y_fall     = $signed({1'b0, y0}) + $signed({6'b0, vy_inc});

      nxt_state = state;
      nxt_x0    = x0;
      nxt_y0    = y0;
      nxt_vy    = vy;
`ifdef PLAYER_DOUBLE_JUMP_EN
      nxt_air_jump_used = air_jump_used;
`endif

      case (state)
         S_IDLE: begin
            if (jump_now) begin
               nxt_state = S_JUMP;
               nxt_y0    = y_launch_c;
               nxt_vy    = VY_LAUNCH;
            end else if (dir != 12'sd0) begin
               nxt_state = S_WALK;
            end
         end
         S_WALK: begin
            nxt_x0 = x_clamped;
            if (jump_now) begin
               nxt_state = S_JUMP;
               nxt_y0    = y_launch_c;
               nxt_vy    = VY_LAUNCH;
            end else if (dir == 12'sd0) begin
               nxt_state = S_IDLE;
            end
         end
         S_JUMP: begin
            nxt_x0 = x_clamped;
            if (y_jmp < 12'sd0) begin
               nxt_y0    = 11'd0;
               nxt_vy    = 6'd0;
               nxt_state = S_FALL;
            end else begin
               nxt_y0 = y_jmp[10:0];
               nxt_vy = (vy > GRAV_V) ? (vy - GRAV_V) : 6'd0;
               if (nxt_vy == 6'd0)
                  nxt_state = S_FALL;
            end
         end
         default: begin
            nxt_x0 = x_clamped;
            if (y_fall >= Y_FLOOR_S) begin
               nxt_y0    = Y_FLOOR_S[10:0];
               nxt_vy    = 6'd0;
               nxt_state = (dir != 12'sd0) ? S_WALK : S_IDLE;
`ifdef PLAYER_DOUBLE_JUMP_EN
               nxt_air_jump_used = 1'b0;
`endif
            end else begin
               nxt_y0 = y_fall[10:0];
               nxt_vy = vy_inc;
            end
         end
      endcase

`ifdef PLAYER_DOUBLE_JUMP_EN
      if ((state == S_JUMP || state == S_FALL) && jump_now && !air_jump_used) begin
         nxt_state         = S_JUMP;
         nxt_y0            = y_launch_c;
         nxt_vy            = VY_LAUNCH;
         nxt_air_jump_used = 1'b1;
      end
`endif

      case (nxt_state)
         S_JUMP:  nxt_sid = 2'd2;
         S_FALL:  nxt_sid = 2'd3;
         default: nxt_sid = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         left_s1  <= 1'b0;
         left_s2  <= 1'b0;
         right_s1 <= 1'b0;
         right_s2 <= 1'b0;
         jump_s1  <= 1'b0;
         jump_s2  <= 1'b0;
         jump_s3  <= 1'b0;
         x_d1     <= 11'd0;
         jump_req <= 1'b0;
         state    <= S_IDLE;
         vy       <= 6'd0;
         x0       <= 11'(X_INIT);
         y0       <= 11'(Y_FLOOR);
         ctrl_lo  <= 3'd0;
         color_q  <= 2'd0;
         airborne <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
         air_jump_used <= 1'b0;
`endif
      end else begin
         left_s1  <= btn_left;
         left_s2  <= left_s1;
         right_s1 <= btn_right;
         right_s2 <= right_s1;
         jump_s1  <= btn_jump;
         jump_s2  <= jump_s1;
         jump_s3  <= jump_s2;
         x_d1     <= x;
         color_q  <= color_sel;
         if (frame_tick)
            jump_req <= 1'b0;
         else if (jump_edge)
            jump_req <= 1'b1;
         if (frame_tick) begin
            state    <= nxt_state;
            vy       <= nxt_vy;
            x0       <= nxt_x0;
            y0       <= nxt_y0;
            ctrl_lo  <= {nxt_state == S_WALK, nxt_sid};
            airborne <= (nxt_state == S_JUMP) || (nxt_state == S_FALL);
`ifdef PLAYER_DOUBLE_JUMP_EN
            air_jump_used <= nxt_air_jump_used;
`endif
         end
      end
   end
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: walk, clamps, full jump, coincident and in-air jump edges, reset, colour.
module tb_player_motion_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] x, y;
   logic        btn_left, btn_right, btn_jump;
   logic [1:0]  color_sel;
   logic [10:0] x0, y0;
   logic [4:0]  ctrl;
   logic        airborne;

   int n_checks = 0;
   int n_fail   = 0;

   player_motion_ctrl dut (
      .clk(clk), .reset(reset), .x(x), .y(y),
      .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
      .color_sel(color_sel), .x0(x0), .y0(y0), .ctrl(ctrl), .airborne(airborne)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // x_d1==0 then x==1,y==0 raises frame_tick for exactly one clock
   task automatic frame();
      @(posedge clk); #1 x = 11'd0; y = 11'd0;
      @(posedge clk); #1 x = 11'd1;
      @(posedge clk); #1 x = 11'd100; y = 11'd200;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic jump_pulse();
      btn_jump = 1'b1;
      wait_clk(4);
      btn_jump = 1'b0;
      wait_clk(3);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      reset = 1'b1; x = 11'd100; y = 11'd200;
      btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0; color_sel = 2'b00;
      wait_clk(3);
      chk("rst_x0", x0, 304);
      chk("rst_y0", y0, 448);
      chk("rst_ctrl", ctrl, 0);
      chk("rst_air", airborne, 0);
      reset = 1'b0;

      btn_right = 1'b1;
      wait_clk(5);
      chk("no_tick_x0", x0, 304);

      frame();
      chk("walk_start_x0", x0, 304);
      chk("walk_start_ctrl", ctrl, 5'b00100);
      frames(10);
      chk("walk10_x0", x0, 324);
      chk("walk10_ctrl", ctrl, 5'b00100);

      btn_right = 1'b0;
      wait_clk(3);
      frame();
      chk("release_ctrl", ctrl, 5'b00000);
      chk("release_x0", x0, 324);

      color_sel = 2'b10;
      chk("color_before_edge", ctrl[4:3], 2'b00);
      wait_clk(1);
      chk("color_one_clk", ctrl[4:3], 2'b10);

      btn_right = 1'b1;
      wait_clk(3);
      frame();
      frames(141);
      chk("rclamp_pre_x0", x0, 606);
      for (int i = 0; i < 3; i++) begin
         frame();
         chk("rclamp_x0", x0, 608);
      end

      btn_right = 1'b0; btn_left = 1'b1;
      wait_clk(3);
      frames(303);
      chk("lclamp_pre_x0", x0, 2);
      frame();
      chk("lclamp_x0", x0, 0);
      frame();
      chk("lclamp_hold_x0", x0, 0);
      chk("lclamp_ctrl", ctrl, 5'b10100);

      btn_right = 1'b1;
      wait_clk(3);
      frame();
      chk("both_ctrl", ctrl, 5'b10000);
      chk("both_x0", x0, 0);
      btn_right = 1'b0; btn_left = 1'b0;
      wait_clk(3);

      // full jump
      jump_pulse();
      frame();
      chk("launch_y0", y0, 438);
      chk("launch_ctrl", ctrl, 5'b10010);
      chk("launch_air", airborne, 1);
      frames(9);
      chk("apex_y0", y0, 393);
      chk("apex_ctrl", ctrl, 5'b10011);
      frames(10);
      chk("fall10_y0", y0, 445);
      chk("fall10_air", airborne, 1);
      frame();
      chk("land_y0", y0, 448);
      chk("land_air", airborne, 0);
      chk("land_ctrl", ctrl, 5'b10000);

      // jump edge coinciding with the frame tick
      @(posedge clk); #1 btn_jump = 1'b1; x = 11'd7;
      @(posedge clk); #1 x = 11'd0; y = 11'd0;
      @(posedge clk); #1 x = 11'd1;
      @(posedge clk); #1 x = 11'd100; y = 11'd200;
      chk("coincide_y0", y0, 438);
      chk("coincide_air", airborne, 1);
      btn_jump = 1'b0;
      wait_clk(3);
      frames(2);
      chk("air2_y0", y0, 421);

      jump_pulse();
      frame();
`ifdef PLAYER_DOUBLE_JUMP_EN
      chk("second_edge_y0", y0, 411);
      chk("second_edge_ctrl", ctrl, 5'b10010);
`else
      chk("second_edge_y0", y0, 414);
`endif
      jump_pulse();
      frame();
`ifdef PLAYER_DOUBLE_JUMP_EN
      chk("third_edge_y0", y0, 402);
`else
      chk("third_edge_y0", y0, 408);
`endif

      guard = 0;
      while (airborne && guard < 60) begin
         frame();
         guard++;
      end
      chk("land2_timeout", guard < 60, 1);
      chk("land2_y0", y0, 448);
      chk("land2_ctrl", ctrl, 5'b10000);
      frame();
      chk("no_stale_jump_y0", y0, 448);
      chk("no_stale_jump_air", airborne, 0);

      // reset mid-jump
      jump_pulse();
      frames(3);
      chk("prereset_y0", y0, 421);
      reset = 1'b1;
      wait_clk(1);
      chk("midjump_rst_x0", x0, 304);
      chk("midjump_rst_y0", y0, 448);
      chk("midjump_rst_ctrl", ctrl, 0);
      chk("midjump_rst_air", airborne, 0);
      reset = 1'b0;
      wait_clk(1);
      chk("post_rst_color", ctrl[4:3], 2'b10);
      frame();
      chk("post_rst_y0", y0, 448);
      chk("post_rst_air", airborne, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
